icepic_sequencer: RTL and testbench
===================================

# icepic_sequencer

Instruction fetch/decode sequencer for the iCEPIC baseline core. It fetches 12-bit instructions from a synchronous program ROM and decodes each into an `alu_op_t` command with operand selects for the combinational `alu`. It consumes the ALU's `skip_flag_out` and `status_update_out` to squash skipped instructions and gate write-back, and it owns the PC and the 2-level call stack.

## Interface
- `RESET_VEC`, 9'h1FF, PC value loaded by reset.
- `clk`  in  1  core clock.
- `rst_n`  in  1  reset. Asynchronous assert, active-low.
- `rom_addr_out`  out  9  program ROM address. Equal to the PC register.
- `rom_data_in`  in  12  ROM data, valid one clock after `rom_addr_out`.
- `alu_op_out`  out  alu_op_t  ALU operation.
- `bit_pos_out`  out  3  bit index; instruction bits [7:5].
- `literal_out`  out  8  instruction bits [7:0].
- `b_sel_lit_out`  out  1  1 = ALU `b_in` takes `literal_out`; 0 = it takes file data.
- `file_addr_out`  out  5  instruction bits [4:0].
- `f_we_out`  out  1  write the ALU result to the file register.
- `w_we_out`  out  1  write the ALU result to W.
- `status_we_out`  out  1  write the ALU status.
- `skip_flag_in`  in  1  from ALU `skip_flag_out`.
- `status_update_in`  in  1  from ALU `status_update_out`.

## Operation
- FSM with two states.
  - FETCH: `rom_addr_out`=PC; PC<=PC+1 (9-bit, 0x1FF wraps to 0x000); go to EXEC.
  - EXEC: decode `rom_data_in`; go to FETCH.
- Outputs are ALU_NOP with all write enables 0 in FETCH, in reset, and in a squashed EXEC.
- ALU operands: `a_in`=W; `b_in`=file data or literal.
- Decode (d = bit5: 1 selects f, 0 selects W):
  - NOP, OPTION, SLEEP, CLRWDT and TRIS: ALU_NOP, no writes.
  - MOVWF: ALU_NOP, `f_we_out`=1.
  - CLRW: ALU_CLR, W write. CLRF: ALU_CLR, f write.
  - SUBWF, DECF, IORWF, ANDWF, XORWF, ADDWF, MOVF, COMF, INCF, DECFSZ, RRF, RLF, SWAPF, INCFSZ: the matching ALU op; write W or f according to d.
  - BCF/BSF: ALU_BIT_CLEAR/ALU_BIT_SET, f write.
  - BTFSC/BTFSS: ALU_BIT_BTFSC/ALU_BIT_BTFSS, no writes.
  - MOVLW, IORLW, ANDLW, XORLW: ALU_MOVF, ALU_OR, ALU_AND, ALU_XOR with `b_sel_lit_out`=1, W write.
  - RETLW: ALU_MOVF with literal, W write, pop stack into PC.
  - CALL: push PC; PC<={1'b0,k[7:0]}.
  - GOTO: PC<=k[8:0].
- `status_we_out` = EXEC & !squash & `status_update_in`.
- Skip:
  - `skip_flag_in`=1 in a non-squashed EXEC sets `skip_pending`.
  - The next EXEC is squashed: NOP outputs, branch/stack actions ignored, `skip_flag_in` ignored. `skip_pending` clears at the end of that EXEC.
- Stack, two entries:
  - Push: s1<=s0, s0<=PC. On overflow the oldest entry is lost.
  - Pop: PC<=s0, s0<=s1, s1 unchanged. Underflow repeats s1.

## Timing
- Each instruction takes 2 clocks: FETCH, then EXEC.
- Write enables are combinational in EXEC. Register-file, W and status writes commit on the clock edge that ends EXEC.
- A branch in EXEC loads PC on that edge, so the following FETCH uses the target. No flush penalty.
- The ROM is sampled only in EXEC.
- Reset values: state=FETCH, PC=`RESET_VEC`, s0=s1=0, `skip_pending`=0.
  - Therefore `rom_addr_out`=`RESET_VEC` and all write enables are 0 during reset.
  - Reset asserted mid-EXEC drops any write enables immediately and discards the instruction.
- A squashed GOTO, CALL or RETLW does not change PC or the stack; PC has already advanced past it.
- If a skip instruction is itself squashed, it cannot set a new skip.

## Test plan
- Reset/wrap: release reset -> `rom_addr_out`=0x1FF, then 0x000 two clocks later. No write enables during reset.
- ALU decode: ADDWF 0x07 with d=1 (0x1E7) -> `alu_op_out`=ALU_ADD, `file_addr_out`=7, `f_we_out`=1, `w_we_out`=0. MOVLW 0xA5 (0xCA5) -> ALU_MOVF, `b_sel_lit_out`=1, `literal_out`=0xA5, `w_we_out`=1.
- Skip: DECFSZ at 0x010 with `skip_flag_in`=1 -> instruction at 0x011 (GOTO 0x100) squashed, next fetch 0x012. With `skip_flag_in`=0 -> next fetch is 0x100.
- Call/return: CALL 0x40 at 0x005, then RETLW 0x33 -> fetches 0x040, then 0x006. W write of 0x33 via literal. Three nested CALLs then three RETLWs -> the third return repeats the oldest surviving address.
- Bit ops: BSF 0x06,4 (0x586) -> ALU_BIT_SET, `bit_pos_out`=4, `f_we_out`=1. BTFSS 0x06,4 with `skip_flag_in`=1 -> next instruction squashed.
- Status gating: `status_update_in`=1 during a squashed EXEC -> `status_we_out`=0. During a normal EXEC -> 1.

Source files
------------

// File: rtl/icepic_sequencer.sv
// iCEPIC baseline fetch/decode sequencer: two-clock FETCH/EXEC cycle, PC,
// two-entry call stack and skip squashing around the combinational ALU.
package icepic_pkg;
  typedef enum logic [4:0] {
    ALU_NOP, ALU_CLR, ALU_SUB, ALU_DEC, ALU_OR, ALU_AND, ALU_XOR, ALU_ADD,
    ALU_MOVF, ALU_COMF, ALU_INC, ALU_DECFSZ, ALU_RRF, ALU_RLF, ALU_SWAPF,
    ALU_INCFSZ, ALU_BIT_CLEAR, ALU_BIT_SET, ALU_BIT_BTFSC, ALU_BIT_BTFSS
  } alu_op_t;
endpackage

module icepic_sequencer
  import icepic_pkg::*;
#(
  parameter logic [8:0] RESET_VEC = 9'h1FF
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [8:0]  rom_addr_out,
  input  logic [11:0] rom_data_in,
  output alu_op_t     alu_op_out,
  output logic [2:0]  bit_pos_out,
  output logic [7:0]  literal_out,
  output logic        b_sel_lit_out,
  output logic [4:0]  file_addr_out,
  output logic        f_we_out,
  output logic        w_we_out,
  output logic        status_we_out,
  input  logic        skip_flag_in,
  input  logic        status_update_in
);

  typedef enum logic {FETCH, EXEC} state_t;

  state_t     state, state_nxt;
  logic [8:0] pc, pc_nxt;
  logic [8:0] s0, s0_nxt;
  logic [8:0] s1, s1_nxt;
  logic       skip_pending, skip_nxt;
  logic       dest_f;

  assign rom_addr_out  = pc;
  assign bit_pos_out   = rom_data_in[7:5];
  assign literal_out   = rom_data_in[7:0];
  assign file_addr_out = rom_data_in[4:0];
  assign dest_f        = rom_data_in[5];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= FETCH;
      pc           <= RESET_VEC;
      s0           <= 9'h000;
      s1           <= 9'h000;
      skip_pending <= 1'b0;
    end else begin
      state        <= state_nxt;
      pc           <= pc_nxt;
      s0           <= s0_nxt;
      s1           <= s1_nxt;
      skip_pending <= skip_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    pc_nxt        = pc;
    s0_nxt        = s0;
    s1_nxt        = s1;
    skip_nxt      = skip_pending;
    alu_op_out    = ALU_NOP;
    b_sel_lit_out = 1'b0;
    f_we_out      = 1'b0;
    w_we_out      = 1'b0;
    status_we_out = 1'b0;

    case (state)
      FETCH: begin
        pc_nxt    = pc + 9'd1;
        state_nxt = EXEC;
      end
      EXEC: begin
        state_nxt = FETCH;
        // A squashed slot does nothing at all, including raising a new skip.
        if (skip_pending) begin
          skip_nxt = 1'b0;
        end else begin
          skip_nxt      = skip_flag_in;
          status_we_out = status_update_in;
          case (rom_data_in[11:10])
            2'b00: begin
              case (rom_data_in[9:6])
                4'b0000: f_we_out = dest_f;
                4'b0001: begin
                  alu_op_out = ALU_CLR;
                  f_we_out   = dest_f;
                  w_we_out   = !dest_f;
                end
                default: begin
                  case (rom_data_in[9:6])
                    4'b0010: alu_op_out = ALU_SUB;
                    4'b0011: alu_op_out = ALU_DEC;
                    4'b0100: alu_op_out = ALU_OR;
                    4'b0101: alu_op_out = ALU_AND;
                    4'b0110: alu_op_out = ALU_XOR;
                    4'b0111: alu_op_out = ALU_ADD;
                    4'b1000: alu_op_out = ALU_MOVF;
                    4'b1001: alu_op_out = ALU_COMF;
                    4'b1010: alu_op_out = ALU_INC;
                    4'b1011: alu_op_out = ALU_DECFSZ;
                    4'b1100: alu_op_out = ALU_RRF;
                    4'b1101: alu_op_out = ALU_RLF;
                    4'b1110: alu_op_out = ALU_SWAPF;
                    default: alu_op_out = ALU_INCFSZ;
                  endcase
                  f_we_out = dest_f;
                  w_we_out = !dest_f;
                end
              endcase
            end
            2'b01: begin
              case (rom_data_in[9:8])
                2'b00: begin
                  alu_op_out = ALU_BIT_CLEAR;
                  f_we_out   = 1'b1;
                end
                2'b01: begin
                  alu_op_out = ALU_BIT_SET;
                  f_we_out   = 1'b1;
                end
                2'b10:   alu_op_out = ALU_BIT_BTFSC;
                default: alu_op_out = ALU_BIT_BTFSS;
              endcase
            end
            2'b10: begin
              case (rom_data_in[9:8])
                2'b00: begin
                  alu_op_out    = ALU_MOVF;
                  b_sel_lit_out = 1'b1;
                  w_we_out      = 1'b1;
                  pc_nxt        = s0;
                  s0_nxt        = s1;
                end
                // PC has already advanced, so it is the return address.
                2'b01: begin
                  s1_nxt = s0;
                  s0_nxt = pc;
                  pc_nxt = {1'b0, rom_data_in[7:0]};
                end
                default: pc_nxt = rom_data_in[8:0];
              endcase
            end
            default: begin
              b_sel_lit_out = 1'b1;
              w_we_out      = 1'b1;
              case (rom_data_in[9:8])
                2'b00:   alu_op_out = ALU_MOVF;
                2'b01:   alu_op_out = ALU_OR;
                2'b10:   alu_op_out = ALU_AND;
                default: alu_op_out = ALU_XOR;
              endcase
            end
          endcase
        end
      end
      default: state_nxt = FETCH;
    endcase
  end

endmodule

// File: tb/tb_icepic_sequencer.sv
// Directed bench for icepic_sequencer: the bench plays the program ROM and
// walks a hand-traced program through reset, decode, skip, call and return.
module tb_icepic_sequencer;
  import icepic_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [8:0]  rom_addr_out;
  logic [11:0] rom_data_in;
  alu_op_t     alu_op_out;
  logic [2:0]  bit_pos_out;
  logic [7:0]  literal_out;
  logic        b_sel_lit_out;
  logic [4:0]  file_addr_out;
  logic        f_we_out;
  logic        w_we_out;
  logic        status_we_out;
  logic        skip_flag_in;
  logic        status_update_in;

  int check_count = 0;
  int error_count = 0;

  always #5 clk = ~clk;

  icepic_sequencer #(.RESET_VEC(9'h1FF)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .rom_addr_out     (rom_addr_out),
    .rom_data_in      (rom_data_in),
    .alu_op_out       (alu_op_out),
    .bit_pos_out      (bit_pos_out),
    .literal_out      (literal_out),
    .b_sel_lit_out    (b_sel_lit_out),
    .file_addr_out    (file_addr_out),
    .f_we_out         (f_we_out),
    .w_we_out         (w_we_out),
    .status_we_out    (status_we_out),
    .skip_flag_in     (skip_flag_in),
    .status_update_in (status_update_in)
  );

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    check_count++;
    if (observed !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Called at a FETCH negedge: checks the fetch address, serves the ROM word,
  // then moves into EXEC and presents the ALU feedback for that instruction.
  task automatic apply_stimulus(input string tag, input logic [8:0] exp_addr,
                                input logic [11:0] instr, input logic skip,
                                input logic stat);
    check_output({tag, " addr"}, 32'(rom_addr_out), 32'(exp_addr));
    check_output({tag, " fetch we"}, {f_we_out, w_we_out, status_we_out}, 32'h0);
    rom_data_in = instr;
    @(posedge clk);
    @(negedge clk);
    skip_flag_in     = skip;
    status_update_in = stat;
    #1;
  endtask

  task automatic expect_exec(input string tag, input alu_op_t op, input logic f,
                             input logic w, input logic st, input logic bsel);
    check_output({tag, " op"}, 32'(alu_op_out), 32'(op));
    check_output({tag, " f/w/st we"}, {f_we_out, w_we_out, status_we_out}, {f, w, st});
    check_output({tag, " b_sel"}, 32'(b_sel_lit_out), 32'(bsel));
  endtask

  task automatic end_exec();
    @(posedge clk);
    @(negedge clk);
    skip_flag_in     = 1'b0;
    status_update_in = 1'b0;
  endtask

  initial begin
    rst_n            = 1'b0;
    rom_data_in      = 12'h000;
    skip_flag_in     = 1'b0;
    status_update_in = 1'b1;
    repeat (3) @(negedge clk);
    check_output("reset addr", 32'(rom_addr_out), 32'h1FF);
    check_output("reset we", {f_we_out, w_we_out, status_we_out}, 32'h0);
    check_output("reset op", 32'(alu_op_out), 32'(ALU_NOP));
    status_update_in = 1'b0;
    rst_n = 1'b1;

    apply_stimulus("nop@1ff", 9'h1FF, 12'h000, 1'b0, 1'b0);
    expect_exec("nop@1ff", ALU_NOP, 1'b0, 1'b0, 1'b0, 1'b0);
    end_exec();

    apply_stimulus("addwf", 9'h000, 12'h1E7, 1'b0, 1'b1);
    expect_exec("addwf", ALU_ADD, 1'b1, 1'b0, 1'b1, 1'b0);
    check_output("addwf faddr", 32'(file_addr_out), 32'h07);
    end_exec();

    apply_stimulus("movlw", 9'h001, 12'hCA5, 1'b0, 1'b0);
    expect_exec("movlw", ALU_MOVF, 1'b0, 1'b1, 1'b0, 1'b1);
    check_output("movlw literal", 32'(literal_out), 32'hA5);
    end_exec();

    apply_stimulus("goto 010", 9'h002, 12'hA10, 1'b0, 1'b0);
    expect_exec("goto 010", ALU_NOP, 1'b0, 1'b0, 1'b0, 1'b0);
    end_exec();

    apply_stimulus("decfsz skip", 9'h010, 12'h2E5, 1'b1, 1'b0);
    expect_exec("decfsz skip", ALU_DECFSZ, 1'b1, 1'b0, 1'b0, 1'b0);
    end_exec();

    apply_stimulus("squashed goto", 9'h011, 12'hB00, 1'b1, 1'b1);
    expect_exec("squashed goto", ALU_NOP, 1'b0, 1'b0, 1'b0, 1'b0);
    end_exec();

    apply_stimulus("decfsz noskip", 9'h012, 12'h2E5, 1'b0, 1'b0);
    expect_exec("decfsz noskip", ALU_DECFSZ, 1'b1, 1'b0, 1'b0, 1'b0);
    end_exec();

    apply_stimulus("goto 100", 9'h013, 12'hB00, 1'b0, 1'b0);
    end_exec();

    apply_stimulus("subwf", 9'h100, 12'h083, 1'b0, 1'b1);
    expect_exec("subwf", ALU_SUB, 1'b0, 1'b1, 1'b1, 1'b0);
    end_exec();

    apply_stimulus("goto 005", 9'h101, 12'hA05, 1'b0, 1'b0);
    end_exec();

    apply_stimulus("call 40", 9'h005, 12'h940, 1'b0, 1'b0);
    expect_exec("call 40", ALU_NOP, 1'b0, 1'b0, 1'b0, 1'b0);
    end_exec();

    apply_stimulus("retlw 33", 9'h040, 12'h833, 1'b0, 1'b0);
    expect_exec("retlw 33", ALU_MOVF, 1'b0, 1'b1, 1'b0, 1'b1);
    check_output("retlw literal", 32'(literal_out), 32'h33);
    end_exec();

    apply_stimulus("bsf", 9'h006, 12'h586, 1'b0, 1'b0);
    expect_exec("bsf", ALU_BIT_SET, 1'b1, 1'b0, 1'b0, 1'b0);
    check_output("bsf bitpos", 32'(bit_pos_out), 32'h4);
    end_exec();

    apply_stimulus("btfss", 9'h007, 12'h786, 1'b1, 1'b0);
    expect_exec("btfss", ALU_BIT_BTFSS, 1'b0, 1'b0, 1'b0, 1'b0);
    end_exec();

    apply_stimulus("squashed call", 9'h008, 12'h940, 1'b0, 1'b1);
    expect_exec("squashed call", ALU_NOP, 1'b0, 1'b0, 1'b0, 1'b0);
    end_exec();

    apply_stimulus("call 50", 9'h009, 12'h950, 1'b0, 1'b0);
    end_exec();
    apply_stimulus("call 60", 9'h050, 12'h960, 1'b0, 1'b0);
    end_exec();
    apply_stimulus("call 70", 9'h060, 12'h970, 1'b0, 1'b0);
    end_exec();
    apply_stimulus("retlw 01", 9'h070, 12'h801, 1'b0, 1'b0);
    end_exec();
    apply_stimulus("retlw 02", 9'h061, 12'h802, 1'b0, 1'b0);
    end_exec();
    apply_stimulus("retlw 03", 9'h051, 12'h803, 1'b0, 1'b0);
    end_exec();

    apply_stimulus("goto 1ff", 9'h051, 12'hBFF, 1'b0, 1'b0);
    end_exec();
    apply_stimulus("nop wrap", 9'h1FF, 12'h000, 1'b0, 1'b0);
    end_exec();

    apply_stimulus("movwf", 9'h000, 12'h026, 1'b0, 1'b1);
    expect_exec("movwf", ALU_NOP, 1'b1, 1'b0, 1'b1, 1'b0);
    rst_n = 1'b0;
    #1;
    check_output("midexec reset we", {f_we_out, w_we_out, status_we_out}, 32'h0);
    check_output("midexec reset addr", 32'(rom_addr_out), 32'h1FF);
    @(negedge clk);
    @(negedge clk);
    skip_flag_in     = 1'b0;
    status_update_in = 1'b0;
    rst_n = 1'b1;

    apply_stimulus("post reset", 9'h1FF, 12'h000, 1'b0, 1'b0);
    end_exec();
    apply_stimulus("retlw empty", 9'h000, 12'h800, 1'b0, 1'b0);
    expect_exec("retlw empty", ALU_MOVF, 1'b0, 1'b1, 1'b0, 1'b1);
    end_exec();
    apply_stimulus("stack cleared", 9'h000, 12'h000, 1'b0, 1'b0);
    end_exec();

    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule
